sad_accum: RTL and testbench

SAD_ACCUM -- requirements
Module: sad_accum

---
 rtl/sad_accum.sv | 117 +++++++++++
 tb/tb_sad_accum.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum.sv
// Two-stage packed-byte sum-of-absolute-differences unit (PBSAD / PBSADA).
// S1 holds the per-lane absolute differences, S2 holds the finished result.

module uad8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] d_o
);
   always_comb begin
      if (a_i >= b_i) d_o = a_i - b_i;
      else            d_o = b_i - a_i;
   end
endmodule

module sad_accum #(
   parameter int TAG_W = 6
) (
   input  logic             cpu_clock_i,
   input  logic             cpu_reset_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             accum_i,
   input  logic [31:0]      rs1_i,
   input  logic [31:0]      rs2_i,
   input  logic [31:0]      rs3_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [31:0]      result_o,
   output logic [TAG_W-1:0] result_tag_o
);

   logic [3:0][7:0]  diff;

   logic             s1_valid_q, s1_valid_d;
   logic [3:0][7:0]  s1_diff_q;
   logic [31:0]      s1_rs3_q;
   logic             s1_accum_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             s2_valid_q, s2_valid_d;
   logic [31:0]      s2_result_q, s2_result_d;
   logic [TAG_W-1:0] s2_tag_q;

   logic             accept;
   logic             s1_load;
   logic             s2_load;
   logic [9:0]       sum;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      uad8 u_uad8 (
         .a_i (rs1_i[8*k +: 8]),
         .b_i (rs2_i[8*k +: 8]),
         .d_o (diff[k])
      );
   end

   assign ready_o = !s1_valid_q || !s2_valid_q || result_ready_i;
   assign accept  = valid_i && ready_o && !flush_i;
   assign s2_load = s1_valid_q && (!s2_valid_q || result_ready_i) && !flush_i;
   assign s1_load = accept && (!s1_valid_q || s2_load);

   // Four 8-bit lanes sum to at most 1020, so 10 bits never overflow.
   always_comb begin
      sum = {2'b00, s1_diff_q[0]} + {2'b00, s1_diff_q[1]}
          + {2'b00, s1_diff_q[2]} + {2'b00, s1_diff_q[3]};
      s2_result_d = {22'd0, sum};
      if (s1_accum_q) s2_result_d = s2_result_d + s1_rs3_q;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush_i) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s1_load)      s1_valid_d = 1'b1;
         else if (s2_load) s1_valid_d = 1'b0;
         if (s2_load)             s2_valid_d = 1'b1;
         else if (result_ready_i) s2_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
      if (cpu_reset_i) begin
         s1_valid_q  <= 1'b0;
         s1_diff_q   <= '0;
         s1_rs3_q    <= '0;
         s1_accum_q  <= 1'b0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_tag_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_load) begin
            s1_diff_q  <= diff;
            s1_rs3_q   <= rs3_i;
            s1_accum_q <= accum_i;
            s1_tag_q   <= tag_i;
         end
         if (s2_load) begin
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s1_tag_q;
         end
      end
   end

   assign result_valid_o = s2_valid_q;
   assign result_o       = s2_result_q;
   assign result_tag_o   = s2_tag_q;

endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum: reset, PBSAD/PBSADA values, backpressure,
// streaming, flush and mid-operation reset, against hand-computed results.

module tb_sad_accum;

   localparam int TAG_W = 6;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             valid;
   logic             ready;
   logic             accum;
   logic [31:0]      rs1, rs2, rs3;
   logic [TAG_W-1:0] tag;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      result;
   logic [TAG_W-1:0] res_tag;

   int total = 0;
   int bad   = 0;

   sad_accum #(.TAG_W(TAG_W)) dut (
      .cpu_clock_i    (clk),
      .cpu_reset_i    (rst),
      .flush_i        (flush),
      .valid_i        (valid),
      .ready_o        (ready),
      .accum_i        (accum),
      .rs1_i          (rs1),
      .rs2_i          (rs2),
      .rs3_i          (rs3),
      .tag_i          (tag),
      .result_valid_o (res_valid),
      .result_ready_i (res_ready),
      .result_o       (result),
      .result_tag_o   (res_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic a, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [TAG_W-1:0] t);
      valid = 1'b1;
      accum = a;
      rs1   = x;
      rs2   = y;
      rs3   = z;
      tag   = t;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; valid = 1'b0; accum = 1'b0;
      rs1 = '0; rs2 = '0; rs3 = '0; tag = '0; res_ready = 1'b1;

      // Reset state
      #1;
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_tag", 32'(res_tag), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_ready", 32'(ready), 32'd1);

      // PBSAD, latency 2
      offer(1'b0, 32'h0A05FF00, 32'h050A00FF, 32'h0, 6'd3);
      tick();
      valid = 1'b0;
      check("pbsad_n1_valid", 32'(res_valid), 32'd0);
      tick();
      check("pbsad_valid", 32'(res_valid), 32'd1);
      check("pbsad_result", result, 32'h00000208);
      check("pbsad_tag", 32'(res_tag), 32'd3);
      tick();
      check("pbsad_consumed", 32'(res_valid), 32'd0);

      // PBSADA wrap and zero-difference accumulate, back to back
      offer(1'b1, 32'h0A05FF00, 32'h050A00FF, 32'hFFFFFFFF, 6'd4);
      tick();
      offer(1'b1, 32'h12345678, 32'h12345678, 32'h00000010, 6'd5);
      tick();
      valid = 1'b0;
      check("pbsada_wrap", result, 32'h00000207);
      check("pbsada_wrap_tag", 32'(res_tag), 32'd4);
      tick();
      check("pbsada_zero", result, 32'h00000010);
      check("pbsada_zero_tag", 32'(res_tag), 32'd5);
      tick();

      // Backpressure: two held, third stalls
      res_ready = 1'b0;
      offer(1'b0, 32'd1, 32'd0, 32'd0, 6'd1);
      #1 check("bp_ready1", 32'(ready), 32'd1);
      tick();
      offer(1'b0, 32'd2, 32'd0, 32'd0, 6'd2);
      #1 check("bp_ready2", 32'(ready), 32'd1);
      tick();
      offer(1'b0, 32'd3, 32'd0, 32'd0, 6'd3);
      #1 check("bp_ready3_stall", 32'(ready), 32'd0);
      tick();
      check("bp_hold_tag", 32'(res_tag), 32'd1);
      check("bp_hold_result", result, 32'd1);
      check("bp_still_stalled", 32'(ready), 32'd0);
      tick();
      check("bp_hold_tag2", 32'(res_tag), 32'd1);
      check("bp_hold_result2", result, 32'd1);
      res_ready = 1'b1;
      #1 check("bp_ready_release", 32'(ready), 32'd1);
      tick();
      valid = 1'b0;
      check("bp_out2_valid", 32'(res_valid), 32'd1);
      check("bp_out2_tag", 32'(res_tag), 32'd2);
      tick();
      check("bp_out3_valid", 32'(res_valid), 32'd1);
      check("bp_out3_tag", 32'(res_tag), 32'd3);
      check("bp_out3_result", result, 32'd3);
      tick();
      check("bp_drained", 32'(res_valid), 32'd0);

      // Streaming: 8 ops, one per cycle
      for (int i = 0; i < 8; i++) begin
         offer(1'b0, 32'(i + 10), 32'd0, 32'd0, TAG_W'(i));
         #1 check("stream_ready", 32'(ready), 32'd1);
         tick();
         if (i == 0) begin
            check("stream_first_gap", 32'(res_valid), 32'd0);
         end else begin
            check("stream_valid", 32'(res_valid), 32'd1);
            check("stream_tag", 32'(res_tag), 32'(i - 1));
            check("stream_result", result, 32'(i + 9));
         end
      end
      valid = 1'b0;
      tick();
      check("stream_last_valid", 32'(res_valid), 32'd1);
      check("stream_last_tag", 32'(res_tag), 32'd7);
      tick();
      check("stream_done", 32'(res_valid), 32'd0);

      // Flush with two in flight plus an offer
      res_ready = 1'b0;
      offer(1'b0, 32'd20, 32'd0, 32'd0, 6'd20);
      tick();
      offer(1'b0, 32'd21, 32'd0, 32'd0, 6'd21);
      tick();
      offer(1'b0, 32'd22, 32'd0, 32'd0, 6'd22);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", 32'(res_valid), 32'd0);
      check("flush_ready", 32'(ready), 32'd1);
      res_ready = 1'b1;
      offer(1'b0, 32'h00000909, 32'd0, 32'd0, 6'd9);
      tick();
      valid = 1'b0;
      check("flush_no_ghost", 32'(res_valid), 32'd0);
      tick();
      check("flush_next_valid", 32'(res_valid), 32'd1);
      check("flush_next_tag", 32'(res_tag), 32'd9);
      check("flush_next_result", result, 32'd18);
      tick();
      check("flush_after", 32'(res_valid), 32'd0);

      // Asynchronous reset with both stages full
      res_ready = 1'b0;
      offer(1'b0, 32'd40, 32'd0, 32'd0, 6'd40);
      tick();
      offer(1'b0, 32'd41, 32'd0, 32'd0, 6'd41);
      tick();
      valid = 1'b0;
      check("prerst_full_valid", 32'(res_valid), 32'd1);
      check("prerst_result", result, 32'd40);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", 32'(res_valid), 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_tag", 32'(res_tag), 32'd0);
      check("arst_ready", 32'(ready), 32'd1);
      tick();
      rst = 1'b0;
      res_ready = 1'b1;
      #1 check("arst_release_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("arst_no_stale", 32'(res_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
